uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small power-of-two FIFO. Rising edges of `write`
// enqueue a word; frames go out back to back while words remain queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50M,
    input  logic                          reset_n,
    input  logic                          write,
    input  logic [DATA_BITS-1:0]          write_value,
    output logic                          uart_txd,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [BW-1:0]          baud_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   txd_q;
    logic                   write_q;
    logic                   overrun_q;
    logic                   overrun_d;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW-1:0]          rd_ptr_d;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic                   baud_last;
    logic                   stop_last;
    logic                   data_last;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   enq;
    logic                   push;
    logic                   pop;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;

    assign baud_last  = (baud_q == BW'(DIV - 1));
    assign stop_last  = (bit_q == 3'(STOP_BITS - 1));
    assign data_last  = (bit_q == 3'(DATA_BITS - 1));
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign enq        = write && !write_q;
    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign pop        = !fifo_empty &&
                        ((state_q == S_IDLE) ||
                         (state_q == S_STOP && baud_last && stop_last));
    assign push       = enq && (!fifo_full || pop);
    assign head       = mem[rd_ptr_q];
    assign head_par   = (PARITY == 1) ? ~(^head) : (^head);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = enq && fifo_full && !pop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            write_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            write_q   <= write;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr_q] <= write_value;
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    txd_q  <= 1'b1;
                    if (pop) begin
                        state_q <= S_START;
                        shift_q <= head;
                        par_q   <= head_par;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (data_last) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= S_PAR;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_PAR: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (stop_last) begin
                            bit_q <= '0;
                            // Next queued word starts with no idle gap.
                            if (pop) begin
                                state_q <= S_START;
                                shift_q <= head;
                                par_q   <= head_par;
                                txd_q   <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd   = txd_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign full       = fifo_full;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line
// monitor decodes the selected DUT's serial output cycle by cycle.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  wr_v;
    logic [7:0]  wv;
    logic [4:0]  txd_v;
    logic [4:0]  busy_v;
    logic [4:0]  full_v;
    logic [4:0]  ov_v;
    logic [2:0]  cnt_v [5];

    // u0: 8N1 DIV=10, u1: even parity + 2 stop, u2: odd parity,
    // u3: 7 data bits DIV=434, u4: all defaults (DIV=5208)
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000)) u0 (
        .clk_50M(clk), .reset_n(rst_n), .write(wr_v[0]), .write_value(wv),
        .uart_txd(txd_v[0]), .busy(busy_v[0]), .full(full_v[0]),
        .fifo_count(cnt_v[0]), .overrun(ov_v[0]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk_50M(clk), .reset_n(rst_n), .write(wr_v[1]), .write_value(wv),
        .uart_txd(txd_v[1]), .busy(busy_v[1]), .full(full_v[1]),
        .fifo_count(cnt_v[1]), .overrun(ov_v[1]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(1)) u2 (
        .clk_50M(clk), .reset_n(rst_n), .write(wr_v[2]), .write_value(wv),
        .uart_txd(txd_v[2]), .busy(busy_v[2]), .full(full_v[2]),
        .fifo_count(cnt_v[2]), .overrun(ov_v[2]));
    uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(7)) u3 (
        .clk_50M(clk), .reset_n(rst_n), .write(wr_v[3]), .write_value(wv[6:0]),
        .uart_txd(txd_v[3]), .busy(busy_v[3]), .full(full_v[3]),
        .fifo_count(cnt_v[3]), .overrun(ov_v[3]));
    uart_tx_fifo u4 (
        .clk_50M(clk), .reset_n(rst_n), .write(wr_v[4]), .write_value(wv),
        .uart_txd(txd_v[4]), .busy(busy_v[4]), .full(full_v[4]),
        .fifo_count(cnt_v[4]), .overrun(ov_v[4]));

    typedef struct {
        logic [7:0] data;
        logic       par;
        longint     start;
    } exp_t;

    exp_t       sb [$];
    longint     cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] sel = 3'd0;
    int         div_cur = 10;
    int         bits_cur = 8;
    int         par_cur = 0;
    int         stop_cur = 1;
    bit         mon_en = 1'b0;
    bit         in_frame = 1'b0;
    int         ov_cnt = 0;
    int         full_cnt = 0;
    logic       line;

    assign line = txd_v[sel];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov_v[0]) ov_cnt <= ov_cnt + 1;
        if (full_v[0]) full_cnt <= full_cnt + 1;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("pass %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every cycle of the frame is compared with the expected level.
    initial begin : monitor
        logic       prev;
        exp_t       e;
        longint     t0;
        int         nb;
        int         mism;
        logic [7:0] got;
        logic       gotpar;
        logic       xb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !line) begin
                in_frame = 1'b1;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                end else begin
                    e = sb.pop_front();
                    t0 = cyc;
                    nb = 1 + bits_cur + ((par_cur != 0) ? 1 : 0) + stop_cur;
                    mism = 0;
                    got = '0;
                    gotpar = 1'b0;
                    for (int i = 0; i < nb; i++) begin
                        if (i == 0) xb = 1'b0;
                        else if (i <= bits_cur) xb = e.data[i-1];
                        else if (par_cur != 0 && i == bits_cur + 1) xb = e.par;
                        else xb = 1'b1;
                        for (int c = 0; c < div_cur; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (line !== xb) mism++;
                            if (c == div_cur / 2) begin
                                if (i >= 1 && i <= bits_cur) got[i-1] = line;
                                else if (par_cur != 0 && i == bits_cur + 1) gotpar = line;
                            end
                        end
                    end
                    $display("frame start=%0d data=0x%02h par=%0d bad_cycles=%0d", t0, got, gotpar, mism);
                    check("frame_start", t0, e.start);
                    check("frame_data", longint'(got), longint'(e.data));
                    if (par_cur != 0) check("parity_bit", longint'(gotpar), longint'(e.par));
                    check("bit_timing_errs", longint'(mism), 0);
                end
                in_frame = 1'b0;
            end
            prev = line;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge: the enqueue edge is the next posedge (cyc+1).
    task automatic enq(input int k, input logic [7:0] v, input int hold);
        wv = v;
        wr_v[k] = 1'b1;
        @(negedge clk);
        wv = ~v;
        repeat (hold - 1) @(negedge clk);
        wr_v[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [7:0] v, input logic p,
                        input longint start, input int hold);
        exp_t x;
        x.data = v;
        x.par = p;
        x.start = start;
        sb.push_back(x);
        $display("queue data=0x%02h expect start=%0d", v, start);
        enq(k, v, hold);
    endtask

    task automatic busy_end(input int k, input longint t);
        wait_until(t - 1);
        check("busy_before_end", longint'(busy_v[k]), 1);
        @(negedge clk);
        check("busy_after_end", longint'(busy_v[k]), 0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0", sb.size(), limit);
        end
    endtask

    task automatic config_mon(input logic [2:0] s, input int d, input int b,
                              input int p, input int st);
        sel = s;
        div_cur = d;
        bits_cur = b;
        par_cur = p;
        stop_cur = st;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        longint base;
        int     ov0;
        int     full0;
        rst_n = 1'b0;
        wr_v = '0;
        wv = '0;
        idle(3);
        check("rst_txd_all", longint'(txd_v), 31);
        check("rst_busy", longint'(busy_v[0]), 0);
        check("rst_full", longint'(full_v[0]), 0);
        check("rst_count", longint'(cnt_v[0]), 0);
        check("rst_overrun", longint'(ov_v[0]), 0);
        rst_n = 1'b1;
        idle(2);
        mon_en = 1'b1;

        // Write held 25 cycles: exactly one frame, 1-cycle start latency
        base = cyc + 1;
        send(0, 8'h12, 1'b0, base + 1, 1);
        check("count_after_enq", longint'(cnt_v[0]), 1);
        check("txd_idle_on_enq", longint'(txd_v[0]), 1);
        wr_v[0] = 1'b1;
        @(negedge clk);
        check("count_after_pop", longint'(cnt_v[0]), 0);
        check("txd_start_latency", longint'(txd_v[0]), 0);
        idle(23);
        wr_v[0] = 1'b0;
        busy_end(0, base + 101);
        drain(1000);
        idle(300);

        // Three words 3 cycles apart: contiguous frames
        base = cyc + 1;
        send(0, 8'h34, 1'b0, base + 1, 1);
        idle(2);
        send(0, 8'h56, 1'b0, base + 101, 1);
        idle(2);
        send(0, 8'h78, 1'b0, base + 201, 1);
        busy_end(0, base + 301);
        drain(1000);
        idle(5);

        // Overfill: 6th word dropped; 7th lands on the pop edge while full
        full0 = full_cnt;
        base = cyc + 1;
        send(0, 8'h01, 1'b0, base + 1, 1);
        idle(2);
        send(0, 8'h02, 1'b0, base + 101, 1);
        idle(2);
        send(0, 8'h03, 1'b0, base + 201, 1);
        idle(2);
        send(0, 8'h04, 1'b0, base + 301, 1);
        idle(2);
        send(0, 8'h05, 1'b0, base + 401, 1);
        check("count_full", longint'(cnt_v[0]), 4);
        check("full_flag", longint'(full_v[0]), 1);
        idle(2);
        ov0 = ov_cnt;
        enq(0, 8'h06, 1);
        check("overrun_pulse", longint'(ov_v[0]), 1);
        check("count_after_drop", longint'(cnt_v[0]), 4);
        wait_until(base + 100);
        send(0, 8'h07, 1'b0, base + 501, 1);
        check("count_enq_pop_full", longint'(cnt_v[0]), 4);
        check("no_overrun_on_pop", longint'(ov_v[0]), 0);
        busy_end(0, base + 601);
        drain(2000);
        check("overrun_pulses", longint'(ov_cnt - ov0), 1);
        check("full_seen", longint'(full_cnt > full0), 1);
        idle(5);

        // Reset during data bit 3 with two words queued
        mon_en = 1'b0;
        base = cyc + 1;
        enq(0, 8'h11, 1);
        idle(2);
        enq(0, 8'h22, 1);
        idle(2);
        enq(0, 8'h33, 1);
        check("count_before_reset", longint'(cnt_v[0]), 2);
        wait_until(base + 45);
        rst_n = 1'b0;
        #1;
        check("reset_txd", longint'(txd_v[0]), 1);
        check("reset_count", longint'(cnt_v[0]), 0);
        check("reset_busy", longint'(busy_v[0]), 0);
        idle(3);
        rst_n = 1'b1;
        idle(1);
        mon_en = 1'b1;
        idle(400);
        check("idle_after_reset", longint'(busy_v[0]), 0);
        base = cyc + 1;
        send(0, 8'hA5, 1'b0, base + 1, 1);
        busy_end(0, base + 101);
        drain(1000);
        idle(5);

        // Even parity, two stop bits
        config_mon(3'd1, 10, 8, 2, 2);
        base = cyc + 1;
        send(1, 8'h12, 1'b0, base + 1, 1);
        idle(2);
        send(1, 8'h37, 1'b1, base + 121, 1);
        busy_end(1, base + 241);
        drain(1000);
        idle(5);

        // Odd parity
        config_mon(3'd2, 10, 8, 1, 1);
        base = cyc + 1;
        send(2, 8'h12, 1'b1, base + 1, 1);
        idle(2);
        send(2, 8'h37, 1'b0, base + 111, 1);
        busy_end(2, base + 221);
        drain(1000);
        idle(5);

        // 7 data bits at 115200 baud
        config_mon(3'd3, 434, 7, 0, 1);
        base = cyc + 1;
        send(3, 8'h55, 1'b0, base + 1, 1);
        idle(2);
        send(3, 8'h2A, 1'b0, base + 3907, 1);
        busy_end(3, base + 7813);
        drain(10000);
        idle(5);

        // Defaults: 9600 baud from 50 MHz, write held 25 cycles
        config_mon(3'd4, 5208, 8, 0, 1);
        base = cyc + 1;
        send(4, 8'h12, 1'b0, base + 1, 25);
        busy_end(4, base + 52081);
        drain(60000);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
